// File: rtl/game_round_ctrl.sv
// Round sequencer for the two-player Morse game: latches player1's code, runs player2's guess window, keeps scores, declares a winner.
// Latency: every input sample takes effect on the next rising edge; all outputs are registered.
// Backpressure: none; start is honoured only in IDLE/GAME_OVER, p1_done only in P1_ENTRY. Optional countdown: GAME_TIMER_EN.
module game_round_ctrl #(
    parameter int MAX_ATTEMPTS = 3,
    parameter int ROUND_TIME   = 30,
    parameter int NUM_ROUNDS   = 4
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    input  logic       p1_done,
    input  logic [9:0] p1_value,
    input  logic       p2_complete,
    input  logic [1:0] p2_correct,
    input  logic       tick,
    output logic       p2_next,
    output logic       p1_enable,
    output logic [9:0] code_q,
    output logic [2:0] attempts_left,
    output logic [5:0] timer,
    output logic [3:0] score_p1,
    output logic [3:0] score_p2,
    output logic [2:0] round_num,
    output logic [2:0] state,
    output logic       game_over,
    output logic [1:0] winner
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        P1_ENTRY   = 3'd1,
        P2_GUESS   = 3'd2,
        ROUND_WIN  = 3'd3,
        ROUND_LOSE = 3'd4,
        GAME_OVER  = 3'd5
    } state_t;

    localparam logic [2:0] MAX_L = 3'(MAX_ATTEMPTS);
    localparam logic [2:0] NR_L  = 3'(NUM_ROUNDS);
`ifdef GAME_TIMER_EN
    localparam logic [5:0] TLOAD = 6'(ROUND_TIME);
`else
    // Without the countdown the timer is held at zero and tick has no effect.
    localparam logic [5:0] TLOAD = 6'd0;
    logic unused_tick;
    assign unused_tick = tick;
`endif

    state_t     state_q, state_d;
    logic [9:0] code_lat_q, code_lat_d;
    logic [2:0] att_q, att_d;
    logic [5:0] timer_q, timer_d;
    logic [3:0] sc1_q, sc1_d, sc2_q, sc2_d;
    logic [2:0] round_q, round_d;
    logic       p2_next_q, p2_next_d;
    logic       p1_en_q, p1_en_d;
    logic       over_q, over_d;
    logic [1:0] winner_q, winner_d;
    logic       lose;

    // Next-state, datapath and output decode; outputs are computed from the next state so they register in step with it.
    always_comb begin
        state_d    = state_q;
        code_lat_d = code_lat_q;
        att_d      = att_q;
        timer_d    = timer_q;
        sc1_d      = sc1_q;
        sc2_d      = sc2_q;
        round_d    = round_q;
        lose       = 1'b0;

        case (state_q)
            IDLE, GAME_OVER: begin
                if (start) begin
                    state_d = P1_ENTRY;
                    round_d = 3'd1;
                    sc1_d   = 4'd0;
                    sc2_d   = 4'd0;
                end
            end
            P1_ENTRY: begin
                // An all-zero code is not a valid commit.
                if (p1_done && (p1_value != 10'd0)) begin
                    code_lat_d = p1_value;
                    att_d      = MAX_L;
                    timer_d    = TLOAD;
                    state_d    = P2_GUESS;
                end
            end
            P2_GUESS: begin
                if (p2_complete) begin
                    // A full match wins even if a wrong symbol arrives in the same cycle.
                    state_d = ROUND_WIN;
                end else begin
                    if (p2_correct == 2'b10) begin
                        att_d = att_q - 3'd1;
                        if (att_q == 3'd1) lose = 1'b1;
                    end
`ifdef GAME_TIMER_EN
                    if (tick) begin
                        timer_d = timer_q - 6'd1;
                        if (timer_q == 6'd1) lose = 1'b1;
                    end
`endif
                    if (lose) state_d = ROUND_LOSE;
                end
            end
            ROUND_WIN, ROUND_LOSE: begin
                if (state_q == ROUND_WIN) begin
                    sc2_d = (sc2_q == 4'd15) ? sc2_q : sc2_q + 4'd1;
                end else begin
                    sc1_d = (sc1_q == 4'd15) ? sc1_q : sc1_q + 4'd1;
                end
                if (round_q == NR_L) begin
                    state_d = GAME_OVER;
                end else begin
                    round_d = round_q + 3'd1;
                    state_d = P1_ENTRY;
                end
            end
            default: state_d = IDLE;
        endcase

        p1_en_d   = (state_d == P1_ENTRY);
        p2_next_d = (state_d == P2_GUESS);
        over_d    = (state_d == GAME_OVER);
        winner_d  = 2'b00;
        if (state_d == GAME_OVER) begin
            if (sc1_d > sc2_d)      winner_d = 2'b01;
            else if (sc2_d > sc1_d) winner_d = 2'b10;
            else                    winner_d = 2'b11;
        end
    end

    // State and registered outputs; reset aborts any round without touching scores beyond clearing them.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            code_lat_q <= 10'd0;
            att_q      <= 3'd0;
            timer_q    <= 6'd0;
            sc1_q      <= 4'd0;
            sc2_q      <= 4'd0;
            round_q    <= 3'd0;
            p2_next_q  <= 1'b0;
            p1_en_q    <= 1'b0;
            over_q     <= 1'b0;
            winner_q   <= 2'b00;
        end else begin
            state_q    <= state_d;
            code_lat_q <= code_lat_d;
            att_q      <= att_d;
            timer_q    <= timer_d;
            sc1_q      <= sc1_d;
            sc2_q      <= sc2_d;
            round_q    <= round_d;
            p2_next_q  <= p2_next_d;
            p1_en_q    <= p1_en_d;
            over_q     <= over_d;
            winner_q   <= winner_d;
        end
    end

    assign state         = state_q;
    assign code_q        = code_lat_q;
    assign attempts_left = att_q;
    assign timer         = timer_q;
    assign score_p1      = sc1_q;
    assign score_p2      = sc2_q;
    assign round_num     = round_q;
    assign p2_next       = p2_next_q;
    assign p1_enable     = p1_en_q;
    assign game_over     = over_q;
    assign winner        = winner_q;

endmodule

// File: tb/tb_game_round_ctrl.sv
// Bench for game_round_ctrl with MAX_ATTEMPTS=3, ROUND_TIME=2, NUM_ROUNDS=2.
// Expected snapshots are queued by the stimulus; a monitor pops one on every observable change.
// Covers both builds: the countdown section follows GAME_TIMER_EN.
module tb_game_round_ctrl;

    logic       clock = 1'b0;
    logic       resetn, start, p1_done, p2_complete, tick;
    logic [9:0] p1_value;
    logic [1:0] p2_correct;
    logic       p2_next, p1_enable, game_over;
    logic [9:0] code_q;
    logic [2:0] attempts_left, round_num, state;
    logic [5:0] timer;
    logic [3:0] score_p1, score_p2;
    logic [1:0] winner;

`ifdef GAME_TIMER_EN
    localparam logic [5:0] TL = 6'd2;
`else
    localparam logic [5:0] TL = 6'd0;
`endif

    game_round_ctrl #(.MAX_ATTEMPTS(3), .ROUND_TIME(2), .NUM_ROUNDS(2)) dut (
        .clock(clock), .resetn(resetn), .start(start), .p1_done(p1_done),
        .p1_value(p1_value), .p2_complete(p2_complete), .p2_correct(p2_correct),
        .tick(tick), .p2_next(p2_next), .p1_enable(p1_enable), .code_q(code_q),
        .attempts_left(attempts_left), .timer(timer), .score_p1(score_p1),
        .score_p2(score_p2), .round_num(round_num), .state(state),
        .game_over(game_over), .winner(winner)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [2:0] st;
        logic [2:0] rnd;
        logic [3:0] s1;
        logic [3:0] s2;
        logic [2:0] att;
        logic [5:0] tmr;
        logic [9:0] code;
        logic       p1en;
        logic       p2n;
        logic       go;
        logic [1:0] win;
    } rec_t;

    rec_t       q[$];
    logic [9:0] cur_code = 10'd0;
    logic       mon_en = 1'b0;
    int         mon_total = 0, mon_bad = 0;
    int         chk_total = 0, chk_bad = 0;

    task automatic push(input logic [2:0] st, input logic [2:0] rnd, input logic [3:0] s1,
                        input logic [3:0] s2, input logic [2:0] att, input logic [5:0] tmr,
                        input logic [1:0] win);
        rec_t r;
        r.st = st; r.rnd = rnd; r.s1 = s1; r.s2 = s2; r.att = att; r.tmr = tmr;
        r.code = cur_code; r.p1en = (st == 3'd1); r.p2n = (st == 3'd2);
        r.go = (st == 3'd5); r.win = win;
        q.push_back(r);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        chk_total++;
        if (act !== exp) begin
            chk_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wrong();
        p2_correct = 2'b10; cyc(); p2_correct = 2'b00;
    endtask

    // Monitor: every change of the observable tuple must match the next queued snapshot.
    logic [22:0] prev = '0, cur;
    rec_t        act_r, exp_r;
    always @(negedge clock) begin
        cur = {state, attempts_left, timer, round_num, score_p1, score_p2};
        if (mon_en && (cur !== prev)) begin
            mon_total++;
            act_r = {state, round_num, score_p1, score_p2, attempts_left, timer, code_q,
                     p1_enable, p2_next, game_over, winner};
            if (q.size() == 0) begin
                mon_bad++;
                $display("FAIL unexpected_event: got %h want no change", act_r);
            end else begin
                exp_r = q.pop_front();
                if (act_r !== exp_r) begin
                    mon_bad++;
                    $display("FAIL event: got %h want %h", act_r, exp_r);
                end
            end
        end
        prev = cur;
    end

    initial begin
        resetn = 1'b0; start = 1'b0; p1_done = 1'b0; p2_complete = 1'b0; tick = 1'b0;
        p1_value = 10'd0; p2_correct = 2'b00;

        @(negedge clock);
        check("rst_state", 32'(state), 32'd0);
        check("rst_outputs", 32'({p2_next, p1_enable, game_over, winner, round_num}), 32'd0);
        #2 resetn = 1'b1;
        cyc(2);
        mon_en = 1'b1;

        // Game A, round 1: zero code ignored, then win after 5 cycles.
        push(3'd1, 3'd1, 4'd0, 4'd0, 3'd0, 6'd0, 2'b00);
        start = 1'b1; cyc(); start = 1'b0;
        p1_value = 10'd0; p1_done = 1'b1; cyc(); p1_done = 1'b0;
        cyc(2);
        check("p1_zero_ignored", 32'(state), 32'd1);
        cur_code = 10'b0101110000; p1_value = cur_code;
        push(3'd2, 3'd1, 4'd0, 4'd0, 3'd3, TL, 2'b00);
        p1_done = 1'b1; cyc(); p1_done = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        p1_value = 10'h3FF; p1_done = 1'b1; cyc(); p1_done = 1'b0;
        p2_correct = 2'b11; cyc(); p2_correct = 2'b00;
        cyc();
        push(3'd3, 3'd1, 4'd0, 4'd0, 3'd3, TL, 2'b00);
        push(3'd1, 3'd2, 4'd0, 4'd1, 3'd3, TL, 2'b00);
        p2_complete = 1'b1; cyc(); p2_complete = 1'b0;
        cyc(3);

        // Round 2: three wrong guesses lose the round; game ends in a tie.
        cur_code = 10'h2AA; p1_value = cur_code;
        push(3'd2, 3'd2, 4'd0, 4'd1, 3'd3, TL, 2'b00);
        p1_done = 1'b1; cyc(); p1_done = 1'b0;
        push(3'd2, 3'd2, 4'd0, 4'd1, 3'd2, TL, 2'b00);
        wrong(); cyc();
        push(3'd2, 3'd2, 4'd0, 4'd1, 3'd1, TL, 2'b00);
        wrong(); cyc();
        push(3'd4, 3'd2, 4'd0, 4'd1, 3'd0, TL, 2'b00);
        push(3'd5, 3'd2, 4'd1, 4'd1, 3'd0, TL, 2'b11);
        wrong(); cyc(3);

        // Game B: restart from GAME_OVER clears round and scores.
        push(3'd1, 3'd1, 4'd0, 4'd0, 3'd0, TL, 2'b00);
        start = 1'b1; cyc(); start = 1'b0;
        cur_code = 10'h155; p1_value = cur_code;
        push(3'd2, 3'd1, 4'd0, 4'd0, 3'd3, TL, 2'b00);
        p1_done = 1'b1; cyc(); p1_done = 1'b0;
`ifdef GAME_TIMER_EN
        push(3'd2, 3'd1, 4'd0, 4'd0, 3'd3, 6'd1, 2'b00);
        tick = 1'b1; cyc(); tick = 1'b0;
        push(3'd4, 3'd1, 4'd0, 4'd0, 3'd3, 6'd0, 2'b00);
        push(3'd1, 3'd2, 4'd1, 4'd0, 3'd3, 6'd0, 2'b00);
        tick = 1'b1; cyc(); tick = 1'b0;
        cyc(3);
        cur_code = 10'h0C3; p1_value = cur_code;
        push(3'd2, 3'd2, 4'd1, 4'd0, 3'd3, TL, 2'b00);
        p1_done = 1'b1; cyc(); p1_done = 1'b0;
        push(3'd2, 3'd2, 4'd1, 4'd0, 3'd2, TL, 2'b00);
        wrong(); cyc();
        push(3'd2, 3'd2, 4'd1, 4'd0, 3'd1, TL, 2'b00);
        wrong(); cyc();
        push(3'd3, 3'd2, 4'd1, 4'd0, 3'd1, TL, 2'b00);
        push(3'd5, 3'd2, 4'd1, 4'd1, 3'd1, TL, 2'b11);
        p2_complete = 1'b1; p2_correct = 2'b10; cyc(); p2_complete = 1'b0; p2_correct = 2'b00;
        cyc(3);
        push(3'd1, 3'd1, 4'd0, 4'd0, 3'd1, TL, 2'b00);
        start = 1'b1; cyc(); start = 1'b0;
        cur_code = 10'h0F0; p1_value = cur_code;
        push(3'd2, 3'd1, 4'd0, 4'd0, 3'd3, TL, 2'b00);
        p1_done = 1'b1; cyc(); p1_done = 1'b0;
`else
        tick = 1'b1; cyc(); tick = 1'b0;
        tick = 1'b1; cyc(); tick = 1'b0;
        cyc(3);
        check("timer_off_state", 32'(state), 32'd2);
        check("timer_off_value", 32'(timer), 32'd0);
        push(3'd2, 3'd1, 4'd0, 4'd0, 3'd2, 6'd0, 2'b00);
        wrong(); cyc();
        push(3'd2, 3'd1, 4'd0, 4'd0, 3'd1, 6'd0, 2'b00);
        wrong(); cyc();
        push(3'd3, 3'd1, 4'd0, 4'd0, 3'd1, 6'd0, 2'b00);
        push(3'd1, 3'd2, 4'd0, 4'd1, 3'd1, 6'd0, 2'b00);
        p2_complete = 1'b1; p2_correct = 2'b10; cyc(); p2_complete = 1'b0; p2_correct = 2'b00;
        cyc(3);
        cur_code = 10'h0F0; p1_value = cur_code;
        push(3'd2, 3'd2, 4'd0, 4'd1, 3'd3, 6'd0, 2'b00);
        p1_done = 1'b1; cyc(); p1_done = 1'b0;
`endif
        for (int i = 0; i < 20 && q.size() != 0; i++) cyc();
        check("queue_drained", 32'(q.size()), 32'd0);

        // Asynchronous reset in the middle of a guess window.
        check("pre_reset_p2_next", 32'(p2_next), 32'd1);
        mon_en = 1'b0;
        @(posedge clock);
        #3 resetn = 1'b0;
        #1;
        check("midrst_state", 32'(state), 32'd0);
        check("midrst_scores", 32'({score_p1, score_p2}), 32'd0);
        check("midrst_p2_next", 32'(p2_next), 32'd0);
        check("midrst_winner", 32'(winner), 32'd0);
        check("midrst_misc", 32'({round_num, attempts_left, code_q}), 32'd0);
        cyc(2);
        resetn = 1'b1;
        cyc(2);

        $display("test done: total=%0d bad=%0d", mon_total + chk_total, mon_bad + chk_bad);
        $finish;
    end

endmodule
